// File: rtl/pipeline_exe_if.sv
// ID-to-EXE and EXE-to-MEM signal bundle for the EXE stage.
// The master side is the ID stage plus MEM consumer; the slave side is the EXE stage.
interface pipeline_exe_if;
   logic        valid_d_i;
   logic [31:0] rs1_data_d_i;
   logic [31:0] rs2_data_d_i;
   logic [31:0] extended_imm_d_i;
   logic        alu_src_b_d_i;
   logic [4:0]  alu_op_d_i;
   logic [31:0] pc_plus4_d_i;
   logic [2:0]  dmem_type_d_i;
   logic        reg_write_en_d_i;
   logic [4:0]  rd_idx_d_i;
   logic [3:0]  result_src_d_i;
   logic        instr_illegal_d_i;
   logic        flush_i;

   logic        stall_e_o;
   logic [31:0] alu_result_e_o;
   logic [31:0] store_data_e_o;
   logic [2:0]  dmem_type_e_o;
   logic [31:0] extended_imm_e_o;
   logic [31:0] pc_plus4_e_o;
   logic        reg_write_en_e_o;
   logic [4:0]  rd_idx_e_o;
   logic [3:0]  result_src_e_o;
   logic        instr_illegal_e_o;
   logic [31:0] bypass_e_o;

   modport master (
      output valid_d_i, rs1_data_d_i, rs2_data_d_i, extended_imm_d_i, alu_src_b_d_i,
             alu_op_d_i, pc_plus4_d_i, dmem_type_d_i, reg_write_en_d_i, rd_idx_d_i,
             result_src_d_i, instr_illegal_d_i, flush_i,
      input  stall_e_o, alu_result_e_o, store_data_e_o, dmem_type_e_o, extended_imm_e_o,
             pc_plus4_e_o, reg_write_en_e_o, rd_idx_e_o, result_src_e_o,
             instr_illegal_e_o, bypass_e_o
   );

   modport slave (
      input  valid_d_i, rs1_data_d_i, rs2_data_d_i, extended_imm_d_i, alu_src_b_d_i,
             alu_op_d_i, pc_plus4_d_i, dmem_type_d_i, reg_write_en_d_i, rd_idx_d_i,
             result_src_d_i, instr_illegal_d_i, flush_i,
      output stall_e_o, alu_result_e_o, store_data_e_o, dmem_type_e_o, extended_imm_e_o,
             pc_plus4_e_o, reg_write_en_e_o, rd_idx_e_o, result_src_e_o,
             instr_illegal_e_o, bypass_e_o
   );
endinterface

// File: rtl/pipeline_exe.sv
// EXE stage: single-cycle ALU plus a fixed-latency iterative RV32M multiply/divide unit.
// While the M unit runs, ID/IF are stalled and MEM receives bubbles.
module pipeline_exe #(
   parameter int XLEN      = 32,
   parameter int MD_CYCLES = 32
) (
   input logic           clk,
   input logic           reset,
   pipeline_exe_if.slave bus
);
   typedef enum logic {IDLE, BUSY} state_t;
   typedef enum logic [1:0] {OUT_BUBBLE, OUT_ALU, OUT_MD} out_sel_t;

   localparam logic [4:0] LAST_CNT = 5'(MD_CYCLES - 1);

   state_t   state, next_state;
   out_sel_t out_sel;
   logic [4:0] cnt, next_cnt;
   logic       md_accept;

   logic [XLEN-1:0] op_a, op_b, alu_result;
   logic            a_signed, b_signed, neg_a, neg_b, is_mul;
   logic [XLEN-1:0] abs_a, abs_b;

   logic [2:0]        md_op;
   logic              md_neg_a, md_neg_b, md_b_zero;
   logic [XLEN-1:0]   md_a_raw, md_operand;
   logic [2*XLEN-1:0] md_acc, md_step, md_prod;
   logic [XLEN:0]     mul_sum, div_shift;
   logic [XLEN-1:0]   div_diff, md_quo, md_rem, md_result;
   logic              div_ge;

   logic [XLEN-1:0] lat_store_data, lat_imm, lat_pc_plus4;
   logic [2:0]      lat_dmem_type;
   logic            lat_reg_write_en, lat_illegal;
   logic [4:0]      lat_rd_idx;
   logic [3:0]      lat_result_src;

   assign op_a = bus.rs1_data_d_i;
   assign op_b = bus.alu_src_b_d_i ? bus.extended_imm_d_i : bus.rs2_data_d_i;

   assign bus.stall_e_o  = ~reset & (((state == IDLE) & bus.valid_d_i & bus.alu_op_d_i[4])
                                     | (state == BUSY));
   assign bus.bypass_e_o = bus.alu_result_e_o;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
      end
   end

   // Flush wins over everything, including a pending M-op accept.
   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      out_sel    = OUT_BUBBLE;
      md_accept  = 1'b0;
      if (bus.flush_i) begin
         next_state = IDLE;
         next_cnt   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.valid_d_i && bus.alu_op_d_i[4]) begin
                  md_accept  = 1'b1;
                  next_state = BUSY;
                  next_cnt   = '0;
               end else if (bus.valid_d_i) begin
                  out_sel = OUT_ALU;
               end
            end
            BUSY: begin
               next_cnt = cnt + 5'd1;
               if (cnt == LAST_CNT) begin
                  next_state = IDLE;
                  next_cnt   = '0;
                  out_sel    = OUT_MD;
               end
            end
            default: next_state = IDLE;
         endcase
      end
   end

   always_comb begin
      alu_result = '0;
      case (bus.alu_op_d_i[3:0])
         4'd0: alu_result = op_a + op_b;
         4'd1: alu_result = op_a - op_b;
         4'd2: alu_result = op_a << op_b[4:0];
         4'd3: alu_result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         4'd4: alu_result = {{(XLEN-1){1'b0}}, op_a < op_b};
         4'd5: alu_result = op_a ^ op_b;
         4'd6: alu_result = op_a >> op_b[4:0];
         4'd7: alu_result = XLEN'($signed(op_a) >>> op_b[4:0]);
         4'd8: alu_result = op_a | op_b;
         4'd9: alu_result = op_a & op_b;
         default: alu_result = '0;
      endcase
   end

   // The M unit works on magnitudes; signs are re-applied once at the end.
   always_comb begin
      a_signed = (bus.alu_op_d_i[2:0] == 3'b001) || (bus.alu_op_d_i[2:0] == 3'b010)
                 || (bus.alu_op_d_i[2:0] == 3'b100) || (bus.alu_op_d_i[2:0] == 3'b110);
      b_signed = (bus.alu_op_d_i[2:0] == 3'b001) || (bus.alu_op_d_i[2:0] == 3'b100)
                 || (bus.alu_op_d_i[2:0] == 3'b110);
      neg_a    = a_signed & op_a[XLEN-1];
      neg_b    = b_signed & op_b[XLEN-1];
      abs_a    = neg_a ? -op_a : op_a;
      abs_b    = neg_b ? -op_b : op_b;
      is_mul   = ~bus.alu_op_d_i[2];
   end

   // Multiply: shift-add with the multiplier in the low half. Divide: restoring,
   // remainder in the high half and quotient shifting into the low half.
   always_comb begin
      mul_sum   = {1'b0, md_acc[2*XLEN-1:XLEN]} + (md_acc[0] ? {1'b0, md_operand} : '0);
      div_shift = {md_acc[2*XLEN-1:XLEN], md_acc[XLEN-1]};
      div_ge    = div_shift >= {1'b0, md_operand};
      div_diff  = div_shift[XLEN-1:0] - md_operand;
      if (md_op[2])
         md_step = div_ge ? {div_diff, md_acc[XLEN-2:0], 1'b1}
                          : {div_shift[XLEN-1:0], md_acc[XLEN-2:0], 1'b0};
      else
         md_step = {mul_sum, md_acc[XLEN-1:1]};
   end

   always_comb begin
      md_prod = (md_neg_a ^ md_neg_b) ? -md_step : md_step;
      md_quo  = md_step[XLEN-1:0];
      md_rem  = md_step[2*XLEN-1:XLEN];
      case (md_op)
         3'b000:                 md_result = md_prod[XLEN-1:0];
         3'b001, 3'b010, 3'b011: md_result = md_prod[2*XLEN-1:XLEN];
         3'b100, 3'b101:         md_result = md_b_zero ? '1 :
                                             ((md_neg_a ^ md_neg_b) ? -md_quo : md_quo);
         default:                md_result = md_b_zero ? md_a_raw :
                                             (md_neg_a ? -md_rem : md_rem);
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         md_op <= '0; md_neg_a <= 1'b0; md_neg_b <= 1'b0; md_b_zero <= 1'b0;
         md_a_raw <= '0; md_operand <= '0; md_acc <= '0;
         lat_store_data <= '0; lat_imm <= '0; lat_pc_plus4 <= '0; lat_dmem_type <= '0;
         lat_reg_write_en <= 1'b0; lat_illegal <= 1'b0; lat_rd_idx <= '0; lat_result_src <= '0;
         bus.alu_result_e_o <= '0; bus.store_data_e_o <= '0; bus.dmem_type_e_o <= '0;
         bus.extended_imm_e_o <= '0; bus.pc_plus4_e_o <= '0; bus.reg_write_en_e_o <= 1'b0;
         bus.rd_idx_e_o <= '0; bus.result_src_e_o <= '0; bus.instr_illegal_e_o <= 1'b0;
      end else begin
         if (md_accept) begin
            md_op      <= bus.alu_op_d_i[2:0];
            md_neg_a   <= neg_a;
            md_neg_b   <= neg_b;
            md_b_zero  <= (op_b == '0);
            md_a_raw   <= op_a;
            md_operand <= is_mul ? abs_a : abs_b;
            md_acc     <= {{XLEN{1'b0}}, (is_mul ? abs_b : abs_a)};
            lat_store_data   <= bus.rs2_data_d_i;
            lat_imm          <= bus.extended_imm_d_i;
            lat_pc_plus4     <= bus.pc_plus4_d_i;
            lat_dmem_type    <= bus.dmem_type_d_i;
            lat_reg_write_en <= bus.reg_write_en_d_i;
            lat_illegal      <= bus.instr_illegal_d_i;
            lat_rd_idx       <= bus.rd_idx_d_i;
            lat_result_src   <= bus.result_src_d_i;
         end else if (state == BUSY) begin
            md_acc <= md_step;
         end

         case (out_sel)
            OUT_ALU: begin
               bus.alu_result_e_o    <= alu_result;
               bus.store_data_e_o    <= bus.rs2_data_d_i;
               bus.dmem_type_e_o     <= bus.dmem_type_d_i;
               bus.extended_imm_e_o  <= bus.extended_imm_d_i;
               bus.pc_plus4_e_o      <= bus.pc_plus4_d_i;
               bus.reg_write_en_e_o  <= bus.reg_write_en_d_i;
               bus.rd_idx_e_o        <= bus.rd_idx_d_i;
               bus.result_src_e_o    <= bus.result_src_d_i;
               bus.instr_illegal_e_o <= bus.instr_illegal_d_i;
            end
            OUT_MD: begin
               bus.alu_result_e_o    <= md_result;
               bus.store_data_e_o    <= lat_store_data;
               bus.dmem_type_e_o     <= lat_dmem_type;
               bus.extended_imm_e_o  <= lat_imm;
               bus.pc_plus4_e_o      <= lat_pc_plus4;
               bus.reg_write_en_e_o  <= lat_reg_write_en;
               bus.rd_idx_e_o        <= lat_rd_idx;
               bus.result_src_e_o    <= lat_result_src;
               bus.instr_illegal_e_o <= lat_illegal;
            end
            default: begin
               bus.alu_result_e_o    <= '0;
               bus.store_data_e_o    <= '0;
               bus.dmem_type_e_o     <= '0;
               bus.extended_imm_e_o  <= '0;
               bus.pc_plus4_e_o      <= '0;
               bus.reg_write_en_e_o  <= 1'b0;
               bus.rd_idx_e_o        <= '0;
               bus.result_src_e_o    <= '0;
               bus.instr_illegal_e_o <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_pipeline_exe.sv
// Scoreboard bench for the EXE stage: directed ALU and M-unit vectors, flush and reset
// behaviour; a monitor pops expected results whenever a write-enabled result reaches MEM.
module tb_pipeline_exe;
   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   pipeline_exe_if bus();

   pipeline_exe dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] result;
      logic [31:0] store;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [3:0]  src;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] pc_cnt   = 32'h0000_1000;

   function automatic void checkOutput(input string name, input logic [31:0] act,
                                       input logic [31:0] exp_val);
      n_checks++;
      if (act !== exp_val) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp_val);
      end
   endfunction

   task automatic driveIdle();
      bus.valid_d_i         = 1'b0;
      bus.rs1_data_d_i      = '0;
      bus.rs2_data_d_i      = '0;
      bus.extended_imm_d_i  = '0;
      bus.alu_src_b_d_i     = 1'b0;
      bus.alu_op_d_i        = '0;
      bus.pc_plus4_d_i      = '0;
      bus.dmem_type_d_i     = '0;
      bus.reg_write_en_d_i  = 1'b0;
      bus.rd_idx_d_i        = '0;
      bus.result_src_d_i    = '0;
      bus.instr_illegal_d_i = 1'b0;
      bus.flush_i           = 1'b0;
   endtask

   task automatic driveOp(input logic [4:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic use_imm, input logic [31:0] imm, input logic [4:0] rd);
      pc_cnt = pc_cnt + 32'd4;
      bus.valid_d_i         = 1'b1;
      bus.rs1_data_d_i      = rs1;
      bus.rs2_data_d_i      = rs2;
      bus.extended_imm_d_i  = imm;
      bus.alu_src_b_d_i     = use_imm;
      bus.alu_op_d_i        = op;
      bus.pc_plus4_d_i      = pc_cnt;
      bus.dmem_type_d_i     = 3'b000;
      bus.reg_write_en_d_i  = 1'b1;
      bus.rd_idx_d_i        = rd;
      bus.result_src_d_i    = 4'h2;
      bus.instr_illegal_d_i = 1'b0;
   endtask

   // Holds the op while stalled; an M op is consumed at the edge ending its last stall cycle.
   task automatic applyStimulus(input logic [4:0] op, input logic [31:0] rs1,
                                input logic [31:0] rs2, input logic use_imm,
                                input logic [31:0] imm, input logic [4:0] rd,
                                input logic [31:0] exp_res, input int exp_stall);
      exp_t e;
      int   stall_cycles = 0;
      int   busy_nonbubble = 0;
      bit   done = 1'b0;
      driveOp(op, rs1, rs2, use_imm, imm, rd);
      e.result = exp_res;
      e.store  = rs2;
      e.imm    = imm;
      e.pc     = pc_cnt;
      e.rd     = rd;
      e.src    = 4'h2;
      sb_q.push_back(e);
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (bus.stall_e_o) begin
            stall_cycles++;
            if (i > 0 && (bus.reg_write_en_e_o !== 1'b0 || bus.alu_result_e_o !== 32'h0))
               busy_nonbubble++;
         end
         if (!bus.stall_e_o || stall_cycles == exp_stall) done = 1'b1;
         @(posedge clk);
         #1;
      end
      driveIdle();
      checkOutput("stall_cycles", 32'(stall_cycles), 32'(exp_stall));
      if (exp_stall > 0) begin
         checkOutput("busy_bubbles", 32'(busy_nonbubble), 32'd0);
         @(negedge clk);
         checkOutput("stall_after_md", 32'(bus.stall_e_o), 32'd0);
         @(posedge clk);
         #1;
      end
   endtask

   always @(negedge clk) begin
      if (reset === 1'b0 && bus.reg_write_en_e_o === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected_output: got rd=%0d result=0x%08h, expected no output",
                     bus.rd_idx_e_o, bus.alu_result_e_o);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            checkOutput("alu_result", bus.alu_result_e_o, e.result);
            checkOutput("bypass", bus.bypass_e_o, e.result);
            checkOutput("rd_idx", 32'(bus.rd_idx_e_o), 32'(e.rd));
            checkOutput("pc_plus4", bus.pc_plus4_e_o, e.pc);
            checkOutput("store_data", bus.store_data_e_o, e.store);
            checkOutput("extended_imm", bus.extended_imm_e_o, e.imm);
            checkOutput("result_src", 32'(bus.result_src_e_o), 32'(e.src));
            checkOutput("dmem_illegal", {28'h0, bus.dmem_type_e_o, bus.instr_illegal_e_o}, 32'h0);
         end
      end
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      reset = 1'b1;
      driveIdle();
      driveOp(5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0, 5'd9);

      @(negedge clk);
      checkOutput("reset_stall_0", 32'(bus.stall_e_o), 32'd0);
      @(negedge clk);
      checkOutput("reset_stall_1", 32'(bus.stall_e_o), 32'd0);
      checkOutput("reset_result", bus.alu_result_e_o, 32'h0);
      checkOutput("reset_we_rd", {26'h0, bus.reg_write_en_e_o, bus.rd_idx_e_o}, 32'h0);
      checkOutput("reset_pc", bus.pc_plus4_e_o, 32'h0);
      reset = 1'b0;
      driveIdle();
      @(negedge clk);
      checkOutput("post_reset_stall", 32'(bus.stall_e_o), 32'd0);
      @(posedge clk);
      #1;

      applyStimulus(5'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0A5A, 5'd1, 32'h8000_0000, 0);
      applyStimulus(5'd7, 32'h8000_0000, 32'hDEAD_BEEF, 1'b1, 32'h0000_0004, 5'd2, 32'hF800_0000, 0);
      applyStimulus(5'd1, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'h0000_0A5A, 5'd3, 32'hFFFF_FFFF, 0);
      applyStimulus(5'd2, 32'h0000_0001, 32'h0000_003F, 1'b0, 32'h0000_0A5A, 5'd4, 32'h8000_0000, 0);
      applyStimulus(5'd3, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0A5A, 5'd5, 32'h0000_0001, 0);
      applyStimulus(5'd4, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0A5A, 5'd6, 32'h0000_0000, 0);
      applyStimulus(5'd6, 32'h8000_0000, 32'h1234_5678, 1'b1, 32'h0000_0004, 5'd7, 32'h0800_0000, 0);
      applyStimulus(5'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'h0000_0A5A, 5'd8, 32'h0FF0_0FF0, 0);
      applyStimulus(5'd8, 32'hF0F0_F0F0, 32'h0F0F_0000, 1'b0, 32'h0000_0A5A, 5'd9, 32'hFFFF_F0F0, 0);
      applyStimulus(5'd9, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'h0000_0A5A, 5'd10, 32'hF000_F000, 0);

      applyStimulus(5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0111, 5'd11, 32'hFFFF_FFFE, 33);
      applyStimulus(5'd16, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0, 32'h0000_0112, 5'd12, 32'hFFFF_FFEB, 33);
      applyStimulus(5'd17, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 32'h0000_0113, 5'd13, 32'hFFFF_FFFF, 33);
      applyStimulus(5'd17, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0114, 5'd14, 32'h4000_0000, 33);
      applyStimulus(5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0115, 5'd15, 32'hFFFF_FFFF, 33);
      applyStimulus(5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0116, 5'd16, 32'h8000_0000, 33);
      applyStimulus(5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0117, 5'd17, 32'h0000_0000, 33);
      applyStimulus(5'd21, 32'h0000_0005, 32'h0000_0000, 1'b0, 32'h0000_0118, 5'd18, 32'hFFFF_FFFF, 33);
      applyStimulus(5'd23, 32'h0000_0005, 32'h0000_0000, 1'b0, 32'h0000_0119, 5'd19, 32'h0000_0005, 33);
      applyStimulus(5'd20, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 32'h0000_011A, 5'd20, 32'hFFFF_FFFD, 33);
      applyStimulus(5'd22, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 32'h0000_011B, 5'd21, 32'hFFFF_FFFF, 33);
      applyStimulus(5'd21, 32'h0000_0064, 32'h0000_0007, 1'b0, 32'h0000_011C, 5'd22, 32'h0000_000E, 33);
      applyStimulus(5'd23, 32'h0000_0064, 32'h0000_0007, 1'b0, 32'h0000_011D, 5'd23, 32'h0000_0002, 33);
      applyStimulus(5'd20, 32'hFFFF_FFF9, 32'h0000_0000, 1'b0, 32'h0000_011E, 5'd24, 32'hFFFF_FFFF, 33);
      applyStimulus(5'd22, 32'hFFFF_FFF9, 32'h0000_0000, 1'b0, 32'h0000_011F, 5'd25, 32'hFFFF_FFF9, 33);

      // Flush while the M unit is at cnt=10.
      driveOp(5'd16, 32'h0000_0003, 32'h0000_0004, 1'b0, 32'h0, 5'd26);
      @(negedge clk);
      checkOutput("flush_accept_stall", 32'(bus.stall_e_o), 32'd1);
      @(posedge clk);
      #1;
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      bus.flush_i = 1'b1;
      @(posedge clk);
      #1;
      driveIdle();
      @(negedge clk);
      checkOutput("flush_stall", 32'(bus.stall_e_o), 32'd0);
      checkOutput("flush_bubble", {bus.alu_result_e_o[30:0], bus.reg_write_en_e_o}, 32'h0);
      @(posedge clk);
      #1;
      applyStimulus(5'd0, 32'h0000_0002, 32'h0000_0003, 1'b0, 32'h0000_0A5A, 5'd27, 32'h0000_0005, 0);

      // Reset in the middle of a divide.
      driveOp(5'd21, 32'h0000_0064, 32'h0000_0007, 1'b0, 32'h0, 5'd28);
      repeat (6) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b1;
      driveIdle();
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("midbusy_reset_stall", 32'(bus.stall_e_o), 32'd0);
      checkOutput("midbusy_reset_result", bus.alu_result_e_o, 32'h0);
      checkOutput("midbusy_reset_rd", 32'(bus.rd_idx_e_o), 32'h0);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("midbusy_post_stall", 32'(bus.stall_e_o), 32'd0);
      @(posedge clk);
      #1;
      applyStimulus(5'd0, 32'h0000_0010, 32'h0000_0020, 1'b0, 32'h0000_0A5A, 5'd29, 32'h0000_0030, 0);

      repeat (3) @(negedge clk);
      checkOutput("scoreboard_drain", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
